// File: rtl/config_chain_pkg.sv
// Shared types and constants for the configuration scan-chain loader.
// Chain length is derived from the per-tile ALM and hyperflex selector bit counts.
package config_chain_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRead,
        StFinish
    } state_e;

    localparam logic ModeLoad = 1'b0;
    localparam logic ModeRead = 1'b1;

    localparam int unsigned HF_CFG_BITS       = 5;
    localparam int unsigned ALM_CFG_BITS      = 15;
    localparam int unsigned TILES_PER_CHAIN   = 2;
    localparam int unsigned DEFAULT_CHAIN_LEN = TILES_PER_CHAIN * (ALM_CFG_BITS + HF_CFG_BITS);

    function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/config_chain_loader_if.sv
// Host and chain-side signal bundle of the configuration chain loader.
// slave is the loader's view; master is the host plus attached chain.
interface config_chain_loader_if #(
    parameter int unsigned WORD_W = 8
);
    logic              start;
    logic              mode;
    logic              abort;
    logic [WORD_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [WORD_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_ready;
    logic              config_in;
    logic              config_en;
    logic              config_out;
    logic              busy;
    logic              done;

    modport slave (
        input  start, mode, abort, wr_data, wr_valid, rd_ready, config_out,
        output wr_ready, rd_data, rd_valid, config_in, config_en, busy, done
    );

    modport master (
        output start, mode, abort, wr_data, wr_valid, rd_ready, config_out,
        input  wr_ready, rd_data, rd_valid, config_in, config_en, busy, done
    );
endinterface

// File: rtl/config_word_deser.sv
// Readback deserialiser: packs chain bits LSB-first into a capture shifter and hands
// complete (or final, zero-padded) words to a one-entry holding register.
module config_word_deser #(
    parameter int unsigned WORD_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              bit_valid_i,
    input  logic              bit_i,
    input  logic              last_i,
    input  logic              rd_ready_i,
    output logic [WORD_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    output logic              stall_o
);

    localparam int unsigned CntW = $clog2(WORD_W);
    localparam logic [CntW-1:0] LastIdx = CntW'(WORD_W - 1);

    logic [WORD_W-1:0] cap_q, cap_d, hold_q, hold_d, cap_word;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              full_q, full_d, hold_valid_q, hold_valid_d, hold_free;

    always_comb begin
        hold_free    = !hold_valid_q || rd_ready_i;
        cap_word     = cap_q | (WORD_W'(bit_i) << cnt_q);
        cap_d        = cap_q;
        cnt_d        = cnt_q;
        full_d       = full_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q && !rd_ready_i;

        if (clear_i) begin
            cap_d        = '0;
            cnt_d        = '0;
            full_d       = 1'b0;
            hold_d       = '0;
            hold_valid_d = 1'b0;
        end else if (full_q) begin
            // A completed word is parked until the holding register drains.
            if (hold_free) begin
                hold_d       = cap_q;
                hold_valid_d = 1'b1;
                cap_d        = '0;
                cnt_d        = '0;
                full_d       = 1'b0;
            end
        end else if (bit_valid_i) begin
            if (cnt_q == LastIdx || last_i) begin
                if (hold_free) begin
                    hold_d       = cap_word;
                    hold_valid_d = 1'b1;
                    cap_d        = '0;
                    cnt_d        = '0;
                end else begin
                    cap_d  = cap_word;
                    full_d = 1'b1;
                end
            end else begin
                cap_d = cap_word;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cap_q        <= '0;
            cnt_q        <= '0;
            full_q       <= 1'b0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
        end else begin
            cap_q        <= cap_d;
            cnt_q        <= cnt_d;
            full_q       <= full_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
        end
    end

    assign rd_data_o  = hold_q;
    assign rd_valid_o = hold_valid_q;
    assign stall_o    = full_d;

endmodule

// File: rtl/config_chain_loader.sv
// Host-side master for a fabric configuration scan chain: serial LOAD of host words
// and non-destructive READ with the chain tail recirculated into its head.
module config_chain_loader
    import config_chain_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = DEFAULT_CHAIN_LEN,
    parameter int unsigned WORD_W    = 8
) (
    input  logic                  config_clk,
    input  logic                  config_rst_n,
    config_chain_loader_if.slave  bus
);

    localparam int unsigned N_WORDS   = ceil_div(CHAIN_LEN, WORD_W);
    localparam int unsigned LAST_BITS = CHAIN_LEN - (N_WORDS - 1) * WORD_W;
    localparam int unsigned BitCntW   = $clog2(CHAIN_LEN + 1);
    localparam int unsigned WordCntW  = $clog2(N_WORDS + 1);
    localparam int unsigned LeftW     = $clog2(WORD_W + 1);

    localparam logic [BitCntW-1:0]  FinalBit = BitCntW'(CHAIN_LEN - 1);
    localparam logic [WordCntW-1:0] LastWord = WordCntW'(N_WORDS - 1);
    localparam logic [WordCntW-1:0] NumWords = WordCntW'(N_WORDS);
    localparam logic [LeftW-1:0]    FullLeft = LeftW'(WORD_W - 1);
    localparam logic [LeftW-1:0]    LastLeft = LeftW'(LAST_BITS - 1);

    state_e              state_q, state_d;
    logic [BitCntW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WordCntW-1:0] word_cnt_q, word_cnt_d;
    logic [WORD_W-1:0]   in_shift_q, in_shift_d;
    logic [LeftW-1:0]    in_left_q, in_left_d;
    logic                config_in_q, config_in_d;
    logic                config_en_q, config_en_d;
    logic                busy, wr_ready, final_shift, deser_clear, deser_stall;

    always_comb begin
        busy        = (state_q == StLoad) || (state_q == StRead);
        wr_ready    = (state_q == StLoad) && (in_left_q == '0) && (word_cnt_q < NumWords);
        final_shift = config_en_q && (bit_cnt_q == FinalBit);
        deser_clear = (busy && bus.abort) || (state_q == StIdle && bus.start);

        state_d     = state_q;
        bit_cnt_d   = config_en_q ? bit_cnt_q + 1'b1 : bit_cnt_q;
        word_cnt_d  = word_cnt_q;
        in_shift_d  = in_shift_q;
        in_left_d   = in_left_q;
        config_in_d = 1'b0;
        config_en_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                bit_cnt_d  = '0;
                word_cnt_d = '0;
                in_left_d  = '0;
                if (bus.start) begin
                    if (bus.mode == ModeRead) begin
                        state_d     = StRead;
                        config_in_d = bus.config_out;
                        config_en_d = 1'b1;
                    end else begin
                        state_d = StLoad;
                    end
                end
            end
            StLoad: begin
                if (final_shift) begin
                    state_d = StFinish;
                end else if (in_left_q != '0) begin
                    config_in_d = in_shift_q[0];
                    config_en_d = 1'b1;
                    in_shift_d  = in_shift_q >> 1;
                    in_left_d   = in_left_q - 1'b1;
                end else if (bus.wr_valid && wr_ready) begin
                    config_in_d = bus.wr_data[0];
                    config_en_d = 1'b1;
                    in_shift_d  = bus.wr_data >> 1;
                    in_left_d   = (word_cnt_q == LastWord) ? LastLeft : FullLeft;
                    word_cnt_d  = word_cnt_q + 1'b1;
                end
            end
            StRead: begin
                // config_in is a registered copy of the tail, so shifts are spaced by an idle
                // cycle to let it pick up the new tail bit; the chain then rotates exactly.
                config_in_d = bus.config_out;
                if (final_shift) begin
                    state_d     = StFinish;
                    config_in_d = 1'b0;
                end else begin
                    config_en_d = !config_en_q && !deser_stall;
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase

        if (busy && bus.abort) begin
            state_d     = StIdle;
            config_en_d = 1'b0;
            config_in_d = 1'b0;
            in_shift_d  = '0;
            in_left_d   = '0;
            word_cnt_d  = '0;
            bit_cnt_d   = '0;
        end
    end

    always_ff @(posedge config_clk or negedge config_rst_n) begin
        if (!config_rst_n) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            word_cnt_q  <= '0;
            in_shift_q  <= '0;
            in_left_q   <= '0;
            config_in_q <= 1'b0;
            config_en_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            word_cnt_q  <= word_cnt_d;
            in_shift_q  <= in_shift_d;
            in_left_q   <= in_left_d;
            config_in_q <= config_in_d;
            config_en_q <= config_en_d;
        end
    end

    config_word_deser #(
        .WORD_W (WORD_W)
    ) u_deser (
        .clk_i       (config_clk),
        .rst_ni      (config_rst_n),
        .clear_i     (deser_clear),
        .bit_valid_i (config_en_q && (state_q == StRead)),
        .bit_i       (bus.config_out),
        .last_i      (bit_cnt_q == FinalBit),
        .rd_ready_i  (bus.rd_ready),
        .rd_data_o   (bus.rd_data),
        .rd_valid_o  (bus.rd_valid),
        .stall_o     (deser_stall)
    );

    assign bus.config_in = config_in_q;
    assign bus.config_en = config_en_q;
    assign bus.wr_ready  = wr_ready;
    assign bus.busy      = busy;
    assign bus.done      = (state_q == StFinish);

endmodule
